// File: rtl/display_pkg.sv
// Shared constants for the MM:SS time display: segment encodings, digit slot
// numbering and the largest legal counter value.
package display_pkg;

    // {g,f,e,d,c,b,a}, active-low, common-anode
    localparam logic [6:0] SEG_LUT [10] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [1:0] DIG_SEC_ONES = 2'd0;
    localparam logic [1:0] DIG_SEC_TENS = 2'd1;
    localparam logic [1:0] DIG_MIN_ONES = 2'd2;
    localparam logic [1:0] DIG_MIN_TENS = 2'd3;

    localparam logic [5:0] MAX_VAL = 6'd59;

    typedef struct packed {
        logic [5:0] min;
        logic [5:0] sec;
    } time_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Digit-slot divider: counts 0..DIV-1 and flags the last count of each slot.
module scan_tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    if (DIV < 2) begin : g_div_chk
        $error("scan_tick_gen: DIV must be at least 2");
    end

    logic [CW-1:0] div;

    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign tick = (div == DIV_LAST);

endmodule

// File: rtl/time_display_mux.sv
// Multiplexed 4-digit MM:SS driver: re-samples the counters, keeps only clean
// in-range values, and freezes one snapshot per refresh frame.
module time_display_mux
    import display_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int FRAME_HZ = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] sec_ctr,
    input  logic [5:0] min_ctr,
    input  logic       blank,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [3:0] an_n,
    output logic       frame_tick
);

    localparam int DIV = CLK_HZ / (4 * FRAME_HZ);

    if (DIV < 2) begin : g_div_chk
        $error("time_display_mux: CLK_HZ/(4*FRAME_HZ) must be at least 2");
    end

    function automatic logic in_range(input time_t t);
        return (t.min <= MAX_VAL) && (t.sec <= MAX_VAL);
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        return (d <= 4'd9) ? SEG_LUT[d] : SEG_OFF;
    endfunction

    logic       slot_tick;
    logic       frame_edge;
    logic [1:0] idx;
    time_t      sync_p0;
    time_t      sync_p1;
    time_t      stable;
    time_t      snap;
    logic [3:0] digit;

    scan_tick_gen #(
        .DIV(DIV)
    ) u_scan_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (slot_tick)
    );

    assign frame_edge = slot_tick && (idx == DIG_MIN_TENS);

    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
        end else if (slot_tick) begin
            idx <= idx + 2'd1;
        end
    end

    // Stage p0/p1: two samples of the slow-domain counters; only an agreeing,
    // in-range pair is trusted, so torn transitions never reach the display.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            stable  <= '0;
        end else begin
            sync_p0 <= '{min: min_ctr, sec: sec_ctr};
            sync_p1 <= sync_p0;
            if ((sync_p0 == sync_p1) && in_range(sync_p0)) begin
                stable <= sync_p0;
            end
        end
    end

    // Frame boundary: one snapshot per frame keeps all four digits coherent.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap       <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_edge;
            if (frame_edge) begin
                snap <= stable;
            end
        end
    end

    always_comb begin
        digit = '0;
        case (idx)
            DIG_SEC_ONES: digit = 4'(snap.sec % 6'd10);
            DIG_SEC_TENS: digit = 4'(snap.sec / 6'd10);
            DIG_MIN_ONES: digit = 4'(snap.min % 6'd10);
            DIG_MIN_TENS: digit = 4'(snap.min / 6'd10);
            default:      digit = '0;
        endcase
    end

    // Output stage: one clock behind idx; colon lights on even seconds.
    always_ff @(posedge clk) begin
        if (reset || blank) begin
            an_n  <= 4'b1111;
            seg_n <= SEG_OFF;
            dp_n  <= 1'b1;
        end else begin
            an_n  <= ~(4'b0001 << idx);
            seg_n <= seg_encode(digit);
            dp_n  <= !((idx == DIG_MIN_ONES) && !snap.sec[0]);
        end
    end

endmodule

// File: tb/tb_time_display_mux.sv
// Bench for time_display_mux at DIV=2: fixed digit vectors, hand corner
// sequences, and randomized input against a slot/frame arithmetic model.
module tb_time_display_mux;

    localparam int CLK_HZ   = 800;
    localparam int FRAME_HZ = 100;
    localparam int DIV      = CLK_HZ / (4 * FRAME_HZ);

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] sec_ctr;
    logic [5:0] min_ctr;
    logic       blank;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [3:0] an_n;
    logic       frame_tick;

    int checks   = 0;
    int failures = 0;

    time_display_mux #(
        .CLK_HZ  (CLK_HZ),
        .FRAME_HZ(FRAME_HZ)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sec_ctr   (sec_ctr),
        .min_ctr   (min_ctr),
        .blank     (blank),
        .seg_n     (seg_n),
        .dp_n      (dp_n),
        .an_n      (an_n),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           S9 = 7'b0010000;
    logic [6:0] ref_seg [10] = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9};

    task automatic check_ok(input bit ok, input string name,
                            input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_ok(act === exp, name, act, exp);
    endtask

    // ---------------- reference model ----------------
    int         cnt;
    logic [11:0] h1, h2, m_stable, m_snap;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_ft;
    bit         model_ok = 0;

    // Slot and frame position follow from the number of clocks since reset.
    task automatic model_step();
        int slot, sv, mv, dig;
        if (reset) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
            cnt = 0; h1 = '0; h2 = '0; m_stable = '0; m_snap = '0;
            model_ok = 1;
        end else begin
            slot = (cnt / DIV) % 4;
            sv = int'(m_snap[5:0]);
            mv = int'(m_snap[11:6]);
            case (slot)
                0: dig = sv % 10;
                1: dig = sv / 10;
                2: dig = mv % 10;
                default: dig = mv / 10;
            endcase
            if (blank) begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an  = ~(4'b0001 << slot);
                e_seg = ref_seg[dig];
                e_dp  = !(slot == 2 && (sv % 2) == 0);
            end
            e_ft = (cnt % (4 * DIV)) == (4 * DIV - 1);
            if (e_ft) m_snap = m_stable;
            if (h1 == h2 && int'(h1[5:0]) <= 59 && int'(h1[11:6]) <= 59) m_stable = h1;
            h2 = h1;
            h1 = {min_ctr, sec_ctr};
            cnt++;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (model_ok)
            check_eq("model", {19'd0, frame_tick, dp_n, an_n, seg_n},
                     {19'd0, e_ft, e_dp, e_an, e_seg});
    end

    // ---------------- vectors ----------------
    typedef struct packed {
        logic [5:0]      min;
        logic [5:0]      sec;
        logic [3:0][6:0] seg;   // [3]=min tens .. [0]=sec ones
        logic            dp;
    } vec_t;

    function automatic int slot_of(input logic [3:0] an);
        case (an)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic hold(input logic [5:0] m, input logic [5:0] s, input int n);
        @(negedge clk);
        min_ctr = m;
        sec_ctr = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_frame(input vec_t v);
        int sl;
        logic [7:0] exp;
        for (int c = 0; c < 2 * 4 * DIV; c++) begin
            @(negedge clk);
            sl = slot_of(an_n);
            if (sl < 0) begin
                check_eq("an_onehot", {28'd0, an_n}, 32'he);
            end else begin
                exp = {(sl == 2) ? v.dp : 1'b1, v.seg[sl]};
                check_eq($sformatf("digit%0d_%0d:%0d", sl, v.min, v.sec),
                         {24'd0, dp_n, seg_n}, {24'd0, exp});
            end
        end
    endtask

    vec_t vecs [7];
    logic [5:0] prev_sec, nv;
    int sl;

    initial begin
        vecs[0] = '{6'd12, 6'd34, {S1, S2, S3, S4}, 1'b0};
        vecs[1] = '{6'd12, 6'd35, {S1, S2, S3, S5}, 1'b1};
        vecs[2] = '{6'd12, 6'd36, {S1, S2, S3, S6}, 1'b0};
        vecs[3] = '{6'd59, 6'd59, {S5, S9, S5, S9}, 1'b1};
        vecs[4] = '{6'd0,  6'd0,  {S0, S0, S0, S0}, 1'b0};
        vecs[5] = '{6'd40, 6'd8,  {S4, S0, S0, S8}, 1'b0};
        vecs[6] = '{6'd7,  6'd26, {S0, S7, S2, S6}, 1'b0};

        reset = 1'b1; blank = 1'b0; sec_ctr = '0; min_ctr = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", {19'd0, frame_tick, dp_n, an_n, seg_n},
                 {19'd0, 1'b0, 1'b1, 4'b1111, 7'h7F});

        // Release: digit 0 first, two clocks per slot, frame_tick every 8.
        reset = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            check_eq($sformatf("rot_an_c%0d", c), {28'd0, an_n},
                     {28'd0, ~(4'b0001 << (((c - 1) / 2) % 4))});
            check_eq($sformatf("rot_ft_c%0d", c), {31'd0, frame_tick},
                     {31'd0, (c % 8) == 0});
            if (c == 1) check_eq("first_digit", {25'd0, seg_n}, {25'd0, S0});
        end

        for (int i = 0; i < 7; i++) begin
            hold(vecs[i].min, vecs[i].sec, 20);
            check_frame(vecs[i]);
        end

        // Out-of-range seconds never reach the display.
        hold(6'd12, 6'd34, 20);
        @(negedge clk);
        sec_ctr = 6'd63;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (an_n == 4'b1110) check_eq("hold_on_63", {25'd0, seg_n}, {25'd0, S4});
        end
        hold(6'd12, 6'd7, 20);
        check_frame('{6'd12, 6'd7, {S1, S2, S0, S7}, 1'b1});

        // Seconds change every clock, then settle on 21.
        prev_sec = 6'd7;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            sl = slot_of(an_n);
            if (sl == 0) check_ok(seg_n == S7 || seg_n == S1, "torn_ones", {25'd0, seg_n}, {25'd0, S1});
            if (sl == 1) check_ok(seg_n == S0 || seg_n == S2, "torn_tens", {25'd0, seg_n}, {25'd0, S2});
            if (c < 10) begin
                do nv = 6'($urandom_range(0, 63)); while (nv == prev_sec);
                sec_ctr = nv;
                prev_sec = nv;
            end else begin
                sec_ctr = 6'd21;
            end
        end
        check_frame('{6'd12, 6'd21, {S1, S2, S2, S1}, 1'b1});

        // Blank mid-frame for 5 clocks.
        repeat (3) @(negedge clk);
        blank = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq($sformatf("blank_c%0d", c), {20'd0, dp_n, an_n, seg_n},
                     {20'd0, 1'b1, 4'b1111, 7'h7F});
        end
        blank = 1'b0;
        @(negedge clk);
        check_ok(slot_of(an_n) >= 0, "blank_release", {28'd0, an_n}, 32'h0);

        // Reset mid-frame clears the snapshot back to 00:00.
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midreset_outputs", {19'd0, frame_tick, dp_n, an_n, seg_n},
                 {19'd0, 1'b0, 1'b1, 4'b1111, 7'h7F});
        reset = 1'b0;
        @(negedge clk);
        check_eq("midreset_first", {21'd0, an_n, seg_n}, {21'd0, 4'b1110, S0});

        // Random phase: bursts of held, torn or invalid values with blanking.
        for (int b = 0; b < 300; b++) begin
            @(negedge clk);
            min_ctr = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 59));
            sec_ctr = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 59));
            blank   = ($urandom_range(0, 9) == 0);
            reset   = ($urandom_range(0, 99) == 0);
            repeat ($urandom_range(0, 11)) @(negedge clk);
            reset = 1'b0;
        end
        blank = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/time_display_mux.md
Name: time_display_mux

Overview:
- Downstream consumer of the seconds/minutes counters: turns sec_ctr and min_ctr into a time-multiplexed 4-digit common-anode 7-segment MM:SS display.
- Runs on the board system clock, not sig_1Hz.
- Re-samples the counter values, rejects torn or invalid samples, and snapshots them once per refresh frame, so a frame never mixes two different times.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency.
- FRAME_HZ, 1000, full 4-digit refresh rate.
- DIV, CLK_HZ/(4*FRAME_HZ), clocks per digit slot, derived (localparam). Must be ≥2; elaboration error otherwise.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high.
- sec_ctr  in  6  seconds value 0..59 from the sig_1Hz domain.
- min_ctr  in  6  minutes value 0..59 from the sig_1Hz domain.
- blank  in  1  1 = all digits off; scanning continues.
- seg_n  out  7  {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.
- an_n  out  4  digit enables, active-low; an_n[0] is the rightmost digit.
- frame_tick  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Clocking and reset:
  - One clock (clk); reset is synchronous and active-high.
  - All state and all outputs are registered.
  - Reset values: an_n=4'b1111, seg_n=7'h7F, dp_n=1, frame_tick=0. Divider, digit index, sync stages, stable register and snapshot all clear to 0.
  - Reset asserted mid-frame wins over every other event in that cycle.
- Divider:
  - div counts 0..DIV-1 and wraps.
  - slot_tick=1 when div==DIV-1.
- Digit index:
  - idx (2 bits) advances on slot_tick, 0→1→2→3→0.
- Input capture (crosses from the sig_1Hz domain):
  - Every clk: s1 <= {min_ctr,sec_ctr}; s2 <= s1.
  - stable <= s1 only when s1==s2 and both fields ≤59. Otherwise stable holds.
  - Result: torn multi-bit transitions and out-of-range values (60..63) are never displayed.
- Frame boundary:
  - Occurs on slot_tick with idx==3.
  - That cycle: snap <= stable, and frame_tick=1 on the next cycle.
- Digit mapping (v/10, v%10; tens ≤5):
  - idx0 = sec ones.
  - idx1 = sec tens.
  - idx2 = min ones.
  - idx3 = min tens.
  - No leading-zero suppression.
- Output registers, loaded every cycle from current idx and snap:
  - an_n = ~(1<<idx), or 4'b1111 when blank.
  - seg_n = SEG_LUT[digit], or 7'h7F when blank.
  - dp_n = 0 only when idx==2, snap.sec[0]==0 and !blank. This gives a colon blink at 0.5 Hz.
- Latency:
  - Output registers lag idx by 1 clk.
  - The first cycle after reset release shows digit 0 = '0' (an_n=1110, seg_n=7'b1000000).
  - A new input value held stable ≥2 clk appears on the display no later than 4*DIV+3 clk later.
- Blank:
  - Takes effect on outputs 1 clk after assertion.
  - Release resumes at the current idx; no frame restart.
- Simultaneous input change and frame boundary:
  - snap takes the pre-change stable value.
  - The new value appears in the next frame.

Decomposition:
- Package display_pkg holds:
  - SEG_LUT[0..9], 7-bit active-low {g..a}.
  - SEG_OFF=7'h7F.
  - Digit index constants DIG_SEC_ONES=0, DIG_SEC_TENS=1, DIG_MIN_ONES=2, DIG_MIN_TENS=3.
  - MAX_VAL=59.
- One sub-module, scan_tick_gen: parameter DIV; ports clk, reset, tick. It is the divider described above.
- BCD split stays inline (combinational).

Test Plan (CLK_HZ=800, FRAME_HZ=100 → DIV=2):
- Reset then release, sec=0, min=0 -> next clk an_n=1110, seg_n=1000000. an_n rotates 1110,1101,1011,0111 every 2 clk. frame_tick pulses every 8 clk.
- Hold min=12, sec=34 for 20 clk -> within one frame the digit order (idx0..3) shows 4,3,2,1: seg_n 0011001, 0110000, 0100100, 1111001. dp_n=0 only in the idx2 slot.
- sec=35 (odd) -> dp_n stays 1 in all slots. sec=36 -> dp_n=0 in the idx2 slot.
- Drive sec=63 for 10 clk, then sec=7 -> 63 is never displayed (previous value held). 7 appears at the next frame boundary.
- Toggle sec_ctr to a different value every clk for 10 clk, then hold 21 -> displayed value is always either the prior stable value or 21. No intermediate value ever appears.
- Assert blank mid-frame for 5 clk -> an_n=1111, seg_n=1111111, dp_n=1 starting 1 clk after assertion. Release resumes at the current idx. Assert reset mid-frame -> reset values appear the next clk and snap clears to 00:00.
